// File: rtl/fifo_bank_sequencer.sv
// fifo_bank_sequencer
//   Sequences a bank of BANKS delay-buffer FIFOs (DEPTH deep each) feeding the
//   systolic MAC array. FILL steers a valid/ready word stream bank-major into
//   the FIFOs. DRAIN shifts every FIFO out, optionally skewed one cycle per
//   lane, and flags valid lanes. DONE pulses done for one cycle.
// Ports:
//   clk, rst_n          clock (rising edge), async active-low reset
//   start, abort        begin a pass (IDLE only) / cancel (highest priority)
//   in_valid, in_ready  operand handshake; in_data is the operand word
//   fifo_en, fifo_d     per-FIFO shift enable and common shift-in data
//   fifo_clr            registered one-cycle clear after an abort
//   lane_valid          lane i FIFO output is valid this cycle
//   busy, done          high in FILL/DRAIN; one-cycle end-of-pass pulse
module fifo_bank_sequencer #(
  parameter int BANKS = 8,
  parameter int DEPTH = 8,
  parameter int BITS  = 64,
  parameter int SKEW  = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [BITS-1:0]  in_data,
  output logic [BANKS-1:0] fifo_en,
  output logic [BITS-1:0]  fifo_d,
  output logic             fifo_clr,
  output logic [BANKS-1:0] lane_valid,
  output logic             busy,
  output logic             done
);

  localparam int TLEN = DEPTH + (BANKS - 1) * SKEW;
  localparam int WW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int BW   = (BANKS > 1) ? $clog2(BANKS) : 1;
  localparam int TW   = (TLEN > 1)  ? $clog2(TLEN)  : 1;

  localparam logic [WW-1:0] W_LAST = WW'(DEPTH - 1);
  localparam logic [BW-1:0] B_LAST = BW'(BANKS - 1);
  localparam logic [TW-1:0] T_LAST = TW'(TLEN - 1);

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_DRAIN, S_DONE} state_t;

  state_t          r_state;
  logic [WW-1:0]   r_word;
  logic [BW-1:0]   r_bank;
  logic [TW-1:0]   r_t;
  logic            r_clr;

  logic            w_fire;
  logic [BANKS-1:0] w_drain_en;

  assign w_fire = (r_state == S_FILL) && in_valid && !abort;

  // Lane i drains during its DEPTH-cycle window, offset by i*SKEW.
  always_comb begin
    w_drain_en = '0;
    for (int i = 0; i < BANKS; i++)
      w_drain_en[i] = (int'(r_t) >= i * SKEW) && (int'(r_t) < i * SKEW + DEPTH);
  end

  // Enables are combinational so an accepted word is written the same cycle.
  always_comb begin
    fifo_en    = '0;
    fifo_d     = '0;
    lane_valid = '0;
    if (w_fire) begin
      fifo_en[r_bank] = 1'b1;
      fifo_d          = in_data;
    end else if (r_state == S_DRAIN && !abort) begin
      fifo_en    = w_drain_en;
      lane_valid = w_drain_en;
    end
  end

  assign in_ready = (r_state == S_FILL) && !abort;
  assign busy     = (r_state == S_FILL) || (r_state == S_DRAIN);
  assign done     = (r_state == S_DONE) && !abort;
  assign fifo_clr = r_clr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_word  <= '0;
      r_bank  <= '0;
      r_t     <= '0;
      r_clr   <= 1'b0;
    end else begin
      r_clr <= abort;
      if (abort) begin
        r_state <= S_IDLE;
        r_word  <= '0;
        r_bank  <= '0;
        r_t     <= '0;
      end else begin
        case (r_state)
          S_IDLE: if (start) r_state <= S_FILL;
          S_FILL: if (w_fire) begin
            if (r_word == W_LAST) begin
              r_word <= '0;
              if (r_bank == B_LAST) begin
                r_bank  <= '0;
                r_t     <= '0;
                r_state <= S_DRAIN;
              end else begin
                r_bank <= r_bank + 1'b1;
              end
            end else begin
              r_word <= r_word + 1'b1;
            end
          end
          S_DRAIN: begin
            if (r_t == T_LAST) begin
              r_t     <= '0;
              r_state <= S_DONE;
            end else begin
              r_t <= r_t + 1'b1;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

endmodule
